// File: rtl/booth_multiplier_seq_pkg.sv
// rtl/booth_multiplier_seq_pkg.sv - shared state encoding and default sizing for the Booth multiplier
package booth_multiplier_seq_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_CAPTURE_DELAY = 150;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth_multiplier_seq_step.sv
// rtl/booth_multiplier_seq_step.sv - one radix-2 Booth iteration: add/sub M, then arithmetic shift of {A,Q,q_1}
module booth_multiplier_seq_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;

  // A carries one guard bit so that -M of the most negative operand stays representable
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q_1})
      2'b01:   w_sum = i_a + w_m_ext;
      2'b10:   w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
  end

  assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - sequential signed Booth multiplier sharing one operand bus for both inputs
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  output logic               done,
  output logic [2*WIDTH-1:0] ans
);

  localparam int DCW = $clog2(CAPTURE_DELAY + 1);
  localparam int ICW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [DCW-1:0]   r_dcnt;
  logic [ICW-1:0]   r_icnt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_a;
  logic             r_q_1;

  logic             w_accept;
  logic             w_capture;
  logic             w_step;
  logic             w_last;
  logic [WIDTH:0]   w_a_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_q_1_nx;

  booth_multiplier_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_a_nx),
    .o_q   (w_q_nx),
    .o_q_1 (w_q_1_nx)
  );

  always_ff @(posedge clk_100MHz) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = WAIT;
      WAIT:    if (w_capture) w_next = CALC;
      CALC:    if (w_last)    w_next = DONE;
      DONE:    if (w_accept)  w_next = WAIT;
      default: w_next = IDLE;
    endcase
  end

  // CALC spends WIDTH edges iterating and one more edge publishing the product
  always_comb begin
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_step    = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE, DONE: w_accept  = start;
      WAIT:       w_capture = (r_dcnt == DCW'(CAPTURE_DELAY - 1));
      CALC: begin
        w_last = (r_icnt == ICW'(WIDTH));
        w_step = ~w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_dcnt <= '0;
      r_icnt <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_a    <= '0;
      r_q_1  <= 1'b0;
      done   <= 1'b0;
      ans    <= '0;
    end else begin
      if (w_accept) begin
        r_m    <= data_in;
        r_dcnt <= '0;
        done   <= 1'b0;
      end
      if (r_state == WAIT) begin
        if (w_capture) begin
          r_q    <= data_in;
          r_a    <= '0;
          r_q_1  <= 1'b0;
          r_icnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
      if (w_step) begin
        r_a    <= w_a_nx;
        r_q    <= w_q_nx;
        r_q_1  <= w_q_1_nx;
        r_icnt <= r_icnt + 1'b1;
      end
      if (w_last) begin
        ans  <= {r_a[WIDTH-1:0], r_q};
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed vector bench for booth_multiplier_seq
module tb_booth_multiplier_seq;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  data_in;
  logic        done;
  logic [15:0] ans;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  booth_multiplier_seq dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .done       (done),
    .ans        (ans)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start on a and present b from edge 99 on; optionally pulse a stray start at edge extra_at
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input int extra_at,
                          output int lat, output logic d0, output logic [15:0] a0);
    @(negedge clk_100MHz);
    start   = 1'b1;
    data_in = a;
    @(posedge clk_100MHz);
    #1;
    start   = 1'b0;
    data_in = 8'h5A;
    d0      = done;
    a0      = ans;
    lat     = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk_100MHz);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      start = (n + 1 == extra_at);
      if (n + 1 == extra_at) data_in = 8'h33;
      if (n == 99)  data_in = b;
      if (n == 151) data_in = 8'hC3;
    end
    start = 1'b0;
  endtask

  int          lat;
  logic        d0;
  logic [15:0] a0;
  logic [15:0] prev;
  int          bad;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clk_100MHz);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ans", {16'd0, ans}, 32'd0);
    rst = 1'b0;

    vecs[0] = '{8'd5,   8'd3,   16'h000F};
    vecs[1] = '{8'hFB,  8'd3,   16'hFFF1};
    vecs[2] = '{8'd5,   8'hFD,  16'hFFF1};
    vecs[3] = '{8'hFB,  8'hFD,  16'h000F};
    vecs[4] = '{8'h7F,  8'h7F,  16'h3F01};
    vecs[5] = '{8'h80,  8'h80,  16'h4000};
    vecs[6] = '{8'h80,  8'h7F,  16'hC080};
    vecs[7] = '{8'h00,  8'hFF,  16'h0000};
    vecs[8] = '{8'hFF,  8'hFF,  16'h0001};

    prev = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      run_mult(vecs[i].a, vecs[i].b, 0, lat, d0, a0);
      chk($sformatf("v%0d_ans", i), {16'd0, ans}, {16'd0, vecs[i].p});
      chk($sformatf("v%0d_latency", i), lat, 32'd159);
      chk($sformatf("v%0d_done_drop", i), {31'd0, d0}, 32'd0);
      chk($sformatf("v%0d_ans_on_accept", i), {16'd0, a0}, {16'd0, prev});
      prev = vecs[i].p;
    end

    bad = 0;
    repeat (100) begin
      @(posedge clk_100MHz);
      #1;
      if (!done || ans !== prev) bad++;
    end
    chk("hold_100", bad, 32'd0);

    run_mult(8'd7, 8'hFE, 50, lat, d0, a0);
    chk("start_in_wait_ans", {16'd0, ans}, 32'h0000FFF2);
    chk("start_in_wait_latency", lat, 32'd159);

    run_mult(8'd12, 8'hF6, 154, lat, d0, a0);
    chk("start_in_calc_ans", {16'd0, ans}, 32'h0000FF88);
    chk("start_in_calc_latency", lat, 32'd159);

    @(negedge clk_100MHz);
    start   = 1'b1;
    data_in = 8'd5;
    @(posedge clk_100MHz);
    #1;
    start   = 1'b0;
    data_in = 8'd3;
    repeat (152) @(posedge clk_100MHz);
    #1;
    rst = 1'b1;
    @(posedge clk_100MHz);
    #1;
    rst = 1'b0;
    chk("rst_calc_done", {31'd0, done}, 32'd0);
    chk("rst_calc_ans", {16'd0, ans}, 32'd0);
    bad = 0;
    repeat (200) begin
      @(posedge clk_100MHz);
      #1;
      if (done || ans !== 16'h0000) bad++;
    end
    chk("rst_calc_stays_idle", bad, 32'd0);

    run_mult(8'd5, 8'd3, 0, lat, d0, a0);
    chk("after_rst_ans", {16'd0, ans}, 32'h0000000F);
    chk("after_rst_latency", lat, 32'd159);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
